eeprom_burst_seq: RTL and testbench
===================================

# eeprom_burst_seq

Burst sequencer sitting directly upstream of `at24c02_ctl`: accepts read/write burst commands plus byte streams, and drives the controller's parent handshake. Drive lines: `address`, `din`, `wr_en`, `parent_ready`, `last`. Feedback lines: `ready`, `dout`. Write data is fully buffered before a transaction starts, and read data is buffered after it, because the controller cannot be stalled mid-transaction. Write bursts are split at EEPROM page boundaries so the device never wraps within a page.

## Interface
Parameters:
- `ADDR_W`, 11, EEPROM byte-address width; matches controller `address`.
- `LEN_W`, 4, burst length field width; a burst is 1..2^LEN_W bytes; both FIFOs are 2^LEN_W deep.
- `PAGE_BYTES`, 8, write page size; power of two, ≤ 2^LEN_W.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1  command handshake.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  start address.
- `cmd_len`  in  LEN_W  byte count minus 1.
- `wdata` in 8, `wdata_valid` in 1, `wdata_ready` out 1  write byte stream.
- `rdata` out 8, `rdata_valid` out 1, `rdata_ready` in 1  read byte stream.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `ctl_address` out ADDR_W, `ctl_din` out 8, `ctl_wr_en` out 1, `ctl_parent_ready` out 1, `ctl_last` out 1  to controller.
- `ctl_dout` in 8, `ctl_ready` in 1  from controller.

## Operation
- **States:** IDLE, FILL, XFER, GAP, DONE.
- **IDLE:**
  - `cmd_ready` = 1 when cmd_wr = 1, or when read-FIFO free slots ≥ cmd_len+1.
  - On handshake, latch addr, wr and remaining = cmd_len+1.
  - Write commands go to FILL; read commands go to XFER.
- **FILL:**
  - `wdata_ready` = 1 until remaining bytes have been pushed into the write FIFO, then go to XFER.
  - `wdata_ready` = 0 in every other state.
- **Segment length (seg):**
  - Write: min(remaining, PAGE_BYTES − (addr mod PAGE_BYTES)).
  - Read: remaining; reads are never split.
- **XFER:**
  - `ctl_parent_ready` = 1, `ctl_address` = segment start address, `ctl_wr_en` = wr.
  - `ctl_din` = write-FIFO head.
  - `ctl_last` = 1 while the byte in flight is the segment's final byte.
  - On each `ctl_ready`: write pops the FIFO; read pushes `ctl_dout`. The segment count then decrements.
  - On `ctl_ready` with `ctl_last` = 1, go to GAP.
- **GAP:**
  - Lasts exactly one cycle with `ctl_parent_ready` = 0.
  - addr += seg, modulo 2^ADDR_W; remaining −= seg.
  - If remaining > 0, go to XFER; otherwise go to DONE.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- **Read FIFO:** drains to `rdata` independently in all states. Space is reserved at command accept, so it never overflows.
- **`ctl_address` / `ctl_wr_en`:** stable for the whole segment.
- **`ctl_din` / `ctl_last`:** change only in the cycle after a `ctl_ready` pulse.

## Timing
- **Reset values:**
  - `cmd_ready` = 0 during rst, 1 in the first cycle after.
  - All other outputs = 0 (`busy`, `done`, `wdata_ready`, `rdata_valid`, `rdata`, all `ctl_*`).
  - Both FIFOs empty; state IDLE.
- **Mid-command reset:** rst mid-command abandons it. The FIFOs are flushed, and the controller is reset by the same rst.
- **Command accept:** the command is accepted at cycle N.
  - Read: `ctl_parent_ready` = 1 at N+1.
  - Write: `wdata_ready` = 1 at N+1; `ctl_parent_ready` = 1 the cycle after the final wdata handshake.
- **Single-byte segment:** `ctl_last` = 1 from the segment's first `ctl_parent_ready` cycle.
- **Byte acceptance:** `ctl_ready` is sampled only while `ctl_parent_ready` = 1; pulses in IDLE, FILL or GAP are ignored.
- **Read FIFO output:** `rdata_valid` rises the cycle after the push. A push and a pop in the same cycle keep the occupancy unchanged.
- **`done`:** asserted one cycle after GAP ends the final segment; `cmd_ready` is asserted again the cycle after that.
- **Read-space check:** free-space for read accept counts slots freed by a same-cycle rdata pop only from the next cycle onward.

## Test plan
- **Aligned 8-byte write and readback:** write at 0x010 with wdata 0xA0..0xA7.
  - Required: one segment; 8 `ctl_ready` pulses; `ctl_last` high only on the 8th byte; one `done` pulse.
  - Then read len 8 at 0x010; rdata must be 0xA0..0xA7 in order.
- **Page split:** write 5 bytes (0x11..0x15) at 0x006.
  - Required: segment addr 0x006 len 2, a one-cycle `ctl_parent_ready` = 0 gap, then segment addr 0x008 len 3.
  - `ctl_last` is high on bytes 2 and 5; a readback at 0x006 returns 0x11..0x15.
- **Single-byte write at 0x7FF:** `ctl_last` high in the first XFER cycle.
  - A 2-byte write at 0x7FF splits into segments 0x7FF and 0x000 (address wrap).
- **Read back-pressure:** read 16 bytes with `rdata_ready` = 0.
  - All 16 bytes are buffered and `done` pulses.
  - A new 1-byte read command keeps `cmd_ready` = 0 until one rdata is popped.
- **Slow write data:** wdata_valid asserted every 3rd cycle for a 4-byte write.
  - `ctl_parent_ready` stays 0 until the 4th byte is buffered, then bytes go out back-to-back.
- **Reset mid-XFER:** assert rst during byte 3 of 8.
  - All outputs 0 next cycle; rdata_valid 0 (FIFOs empty).
  - `cmd_ready` = 1 the cycle after rst falls, and a subsequent 1-byte write/read completes correctly.

Source files
------------

// File: rtl/eeprom_burst_seq.sv
// Burst sequencer in front of at24c02_ctl: buffers write bursts, splits them at page
// boundaries, feeds the controller one segment at a time and buffers read data.
module eeprom_burst_seq #(
   parameter int ADDR_W     = 11,
   parameter int LEN_W      = 4,
   parameter int PAGE_BYTES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [7:0]        wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [7:0]        rdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ctl_address,
   output logic [7:0]        ctl_din,
   output logic              ctl_wr_en,
   output logic              ctl_parent_ready,
   output logic              ctl_last,
   input  logic [7:0]        ctl_dout,
   input  logic              ctl_ready
);

   localparam int DEPTH = 1 << LEN_W;
   localparam int CW    = LEN_W + 1;
   localparam logic [CW-1:0]     ONE      = CW'(1);
   localparam logic [LEN_W-1:0]  PTR_ONE  = LEN_W'(1);
   localparam logic [ADDR_W-1:0] PAGE_MSK = ADDR_W'(PAGE_BYTES - 1);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
   // ready may depend combinationally on the request fields, valid never depends on ready.
   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_XFER,
      S_GAP,
      S_DONE
   } state_t;

   state_t state, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [CW-1:0]     rem_q;
   logic [CW-1:0]     fill_q;
   logic [CW-1:0]     sent_q;

   logic [7:0]        wmem [DEPTH];
   logic [LEN_W-1:0]  w_wr_ptr, w_rd_ptr;

   logic [7:0]        rmem [DEPTH];
   logic [LEN_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_cnt;

   logic [CW-1:0]     page_off, room, seg, need, r_free;
   logic              is_last, hs, cmd_fire;
   logic              w_push, w_pop, r_push, r_pop, fill_last;

   // Segment bounds come from the registered address/remaining, which only move in GAP.
   assign page_off = CW'(addr_q & PAGE_MSK);
   assign room     = CW'(PAGE_BYTES) - page_off;
   assign seg      = (wr_q && (room < rem_q)) ? room : rem_q;
   assign is_last  = (sent_q == (seg - ONE));

   assign need     = {1'b0, cmd_len} + ONE;
   assign r_free   = CW'(DEPTH) - r_cnt;
   assign cmd_ready = !rst && (state == S_IDLE) && (cmd_wr || (r_free >= need));
   assign cmd_fire = cmd_valid && cmd_ready;

   assign hs        = (state == S_XFER) && ctl_ready;
   assign w_push    = (state == S_FILL) && wdata_valid;
   assign fill_last = w_push && (fill_q == (rem_q - ONE));
   assign w_pop     = hs && wr_q;
   assign r_push    = hs && !wr_q;

   assign rdata_valid = (r_cnt != '0);
   assign r_pop       = rdata_valid && rdata_ready;
   assign rdata       = rdata_valid ? rmem[r_rd_ptr] : 8'h00;

   always_comb begin
      state_d          = state;
      busy             = (state != S_IDLE);
      done             = 1'b0;
      wdata_ready      = 1'b0;
      ctl_parent_ready = 1'b0;
      ctl_address      = '0;
      ctl_wr_en        = 1'b0;
      ctl_din          = 8'h00;
      ctl_last         = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_fire) state_d = cmd_wr ? S_FILL : S_XFER;
         end
         S_FILL: begin
            wdata_ready = 1'b1;
            if (fill_last) state_d = S_XFER;
         end
         S_XFER: begin
            ctl_parent_ready = 1'b1;
            ctl_address      = addr_q;
            ctl_wr_en        = wr_q;
            ctl_din          = wr_q ? wmem[w_rd_ptr] : 8'h00;
            ctl_last         = is_last;
            if (hs && is_last) state_d = S_GAP;
         end
         S_GAP: begin
            state_d = (rem_q == seg) ? S_DONE : S_XFER;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         rem_q    <= '0;
         fill_q   <= '0;
         sent_q   <= '0;
         w_wr_ptr <= '0;
         w_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         state <= state_d;
         if (cmd_fire) begin
            addr_q <= cmd_addr;
            wr_q   <= cmd_wr;
            rem_q  <= need;
            fill_q <= '0;
            sent_q <= '0;
         end
         if (w_push) begin
            fill_q   <= fill_q + ONE;
            w_wr_ptr <= w_wr_ptr + PTR_ONE;
         end
         if (w_pop) w_rd_ptr <= w_rd_ptr + PTR_ONE;
         if (hs) sent_q <= sent_q + ONE;
         if (state == S_GAP) begin
            addr_q <= addr_q + ADDR_W'(seg);
            rem_q  <= rem_q - seg;
            sent_q <= '0;
         end
         if (r_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (r_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({r_push, r_pop})
            2'b10:   r_cnt <= r_cnt + ONE;
            2'b01:   r_cnt <= r_cnt - ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage arrays carry no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) wmem[w_wr_ptr] <= wdata;
      if (r_push) rmem[r_wr_ptr] <= ctl_dout;
   end

endmodule

// File: tb/tb_eeprom_burst_seq.sv
// Bench for eeprom_burst_seq: emulates the controller, predicts every byte from a
// byte-level model of bursts, pages and a 2 KiB memory, and checks directed plus random commands.
module tb_eeprom_burst_seq;

   localparam int ADDR_W     = 11;
   localparam int LEN_W      = 4;
   localparam int PAGE_BYTES = 8;
   localparam int MEM_SIZE   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b1;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic [7:0]        wdata = 8'h00;
   logic              wdata_valid = 1'b0, wdata_ready;
   logic [7:0]        rdata;
   logic              rdata_valid, rdata_ready = 1'b0;
   logic              busy, done;
   logic [ADDR_W-1:0] ctl_address;
   logic [7:0]        ctl_din, ctl_dout = 8'h00;
   logic              ctl_wr_en, ctl_parent_ready, ctl_last, ctl_ready = 1'b0;

   always #5 clk = ~clk;

   eeprom_burst_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PAGE_BYTES(PAGE_BYTES)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
      .busy(busy), .done(done),
      .ctl_address(ctl_address), .ctl_din(ctl_din), .ctl_wr_en(ctl_wr_en),
      .ctl_parent_ready(ctl_parent_ready), .ctl_last(ctl_last),
      .ctl_dout(ctl_dout), .ctl_ready(ctl_ready)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] seg_addr;
      logic [ADDR_W-1:0] baddr;
      logic              wr;
      logic              last;
      logic [7:0]        din;
   } xb_t;

   xb_t               xq[$];
   logic [7:0]        exp_q[$];
   logic [7:0]        got_q[$];
   logic [7:0]        wbuf[$];
   logic [ADDR_W-1:0] seg_addr_log[$];
   int                seg_len_log[$];
   logic [7:0]        ref_mem [MEM_SIZE];

   int n_vec = 0, n_fail = 0;
   int hs_cnt = 0, done_cnt = 0, cur_len = 0, wpushed = 0, wneed = 0, rd_release = 0;
   bit gap_due = 0, resume_due = 0, done_due = 0, new_seg = 1;
   bit ctl_always = 0, rd_hold = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input logic exp_cr);
      chk("zero_busy", busy, 0);
      chk("zero_done", done, 0);
      chk("zero_wdata_ready", wdata_ready, 0);
      chk("zero_rdata_valid", rdata_valid, 0);
      chk("zero_rdata", rdata, 0);
      chk("zero_ctl_address", ctl_address, 0);
      chk("zero_ctl_din", ctl_din, 0);
      chk("zero_ctl_wr_en", ctl_wr_en, 0);
      chk("zero_ctl_parent_ready", ctl_parent_ready, 0);
      chk("zero_ctl_last", ctl_last, 0);
      chk("reset_cmd_ready", cmd_ready, exp_cr);
   endtask

   // Controller emulator and per-cycle compare against the expected byte stream.
   initial begin
      xb_t h;
      forever begin
         @(negedge clk);
         if (rst) begin
            ctl_ready   = 1'b0;
            rdata_ready = 1'b0;
            continue;
         end
         if (gap_due) begin
            chk("gap_cycle", ctl_parent_ready, 0);
            gap_due    = 0;
            resume_due = (xq.size() > 0);
            done_due   = (xq.size() == 0);
            ctl_ready  = 1'($urandom_range(0, 1));
         end else begin
            if (resume_due) begin
               chk("resume_after_gap", ctl_parent_ready, 1);
               resume_due = 0;
            end
            if (done_due) begin
               chk("done_after_gap", done, 1);
               done_due = 0;
            end
            if (ctl_parent_ready) begin
               if (xq.size() == 0) begin
                  chk("unexpected_xfer", ctl_parent_ready, 0);
               end else begin
                  h = xq[0];
                  chk("ctl_address", ctl_address, h.seg_addr);
                  chk("ctl_wr_en", ctl_wr_en, h.wr);
                  chk("ctl_last", ctl_last, h.last);
                  if (h.wr) begin
                     chk("ctl_din", ctl_din, h.din);
                     chk("fill_complete", wpushed, wneed);
                  end
                  if (new_seg) begin
                     seg_addr_log.push_back(ctl_address);
                     cur_len = 0;
                     new_seg = 0;
                  end
                  ctl_ready = ctl_always ? 1'b1 : ($urandom_range(0, 2) != 0);
                  ctl_dout  = h.wr ? 8'($urandom) : ref_mem[h.baddr];
                  if (ctl_ready) begin
                     void'(xq.pop_front());
                     hs_cnt++;
                     cur_len++;
                     if (h.last) begin
                        seg_len_log.push_back(cur_len);
                        new_seg = 1;
                        gap_due = 1;
                     end
                  end
               end
            end else begin
               ctl_ready = 1'($urandom_range(0, 1));
               ctl_dout  = 8'($urandom);
            end
         end
         if (rdata_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rdata", rdata_valid, 0);
            else                   chk("rdata", rdata, exp_q[0]);
         end
         if (rd_hold) begin
            rdata_ready = (rd_release > 0);
            if (rd_release > 0) rd_release--;
         end else begin
            rdata_ready = ($urandom_range(0, 1) == 1);
         end
         if (rdata_valid && rdata_ready) begin
            got_q.push_back(rdata);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (done) done_cnt++;
      end
   end

   task automatic do_cmd(input bit wr, input int addr, input int len, input int wgap,
                         input bit b2b, input int abort_at);
      int a, rem, seg, k, t;
      xb_t e;
      if (wr) while (wbuf.size() < len + 1) wbuf.push_back(8'($urandom));
      a = addr; rem = len + 1; k = 0;
      while (rem > 0) begin
         seg = rem;
         if (wr && (PAGE_BYTES - (a % PAGE_BYTES)) < rem) seg = PAGE_BYTES - (a % PAGE_BYTES);
         for (int i = 0; i < seg; i++) begin
            e.seg_addr = ADDR_W'(a);
            e.baddr    = ADDR_W'((a + i) % MEM_SIZE);
            e.wr       = wr;
            e.last     = (i == seg - 1);
            e.din      = wr ? wbuf[k] : 8'h00;
            if (wr) ref_mem[e.baddr] = wbuf[k];
            else    exp_q.push_back(ref_mem[e.baddr]);
            xq.push_back(e);
            k++;
         end
         a   = (a + seg) % MEM_SIZE;
         rem = rem - seg;
      end
      hs_cnt = 0; done_cnt = 0; new_seg = 1;
      seg_addr_log.delete(); seg_len_log.delete();
      wneed = wr ? len + 1 : 0; wpushed = 0;

      @(negedge clk);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = ADDR_W'(addr); cmd_len = LEN_W'(len);
      for (t = 0; t < 500; t++) begin
         #1;
         if (cmd_ready) break;
         @(negedge clk);
      end
      if (t == 500) begin
         chk("cmd_accept_timeout", t, 0);
         cmd_valid = 1'b0; cmd_wr = 1'b1;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_wr = 1'b1;
      #1;
      if (wr) chk("wdata_ready_after_accept", wdata_ready, 1);
      else    chk("parent_ready_after_accept", ctl_parent_ready, 1);

      if (wr) begin
         for (int i = 0; i <= len; i++) begin
            repeat (wgap) @(negedge clk);
            wdata = wbuf[i]; wdata_valid = 1'b1;
            for (t = 0; t < 200; t++) begin
               #1;
               if (wdata_ready) break;
               @(negedge clk);
            end
            if (t == 200) chk("wdata_timeout", t, 0);
            wpushed++;
            @(negedge clk);
            wdata_valid = 1'b0;
         end
         wbuf.delete();
         #1;
         chk("parent_ready_after_fill", ctl_parent_ready, 1);
         if (b2b) begin
            repeat (len) @(negedge clk);
            #2;
            chk("back_to_back", hs_cnt, len + 1);
         end
      end

      if (abort_at >= 0) begin
         for (t = 0; t < 500; t++) begin
            @(negedge clk); #2;
            if (hs_cnt >= abort_at) break;
         end
         rst = 1'b1;
         @(negedge clk); #2;
         chk_zero(1'b0);
         xq.delete(); exp_q.delete();
         gap_due = 0; resume_due = 0; done_due = 0; new_seg = 1; wneed = 0; wpushed = 0;
         @(negedge clk);
         rst = 1'b0;
         #1;
         chk("cmd_ready_after_rst", cmd_ready, 1);
         chk("rdata_valid_after_rst", rdata_valid, 0);
         return;
      end

      for (t = 0; t < 2000; t++) begin
         @(negedge clk); #2;
         if (done) break;
      end
      if (t == 2000) chk("done_timeout", t, 0);
      @(negedge clk); #2;
      chk("done_single_pulse", done, 0);
      chk("done_count", done_cnt, 1);
      chk("busy_after_done", busy, 0);
      chk("cmd_ready_after_done", cmd_ready, 1);
      chk("all_bytes_moved", xq.size(), 0);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 500; t++) begin
         @(negedge clk); #2;
         if (exp_q.size() == 0) break;
      end
      chk("rdata_drain", exp_q.size(), 0);
   endtask

   task automatic chk_got(input string name, input logic [7:0] first, input int n);
      chk({name, "_count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) chk(name, got_q[i], first + 8'(i));
   endtask

   initial begin
      for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'($urandom);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk_zero(1'b0);
      rst = 1'b0;
      #1;
      chk_zero(1'b1);

      // Aligned 8-byte write then readback.
      for (int i = 0; i < 8; i++) wbuf.push_back(8'hA0 + 8'(i));
      do_cmd(1, 'h010, 7, 0, 0, -1);
      chk("aligned_segments", seg_addr_log.size(), 1);
      chk("aligned_seg_addr", seg_addr_log[0], 'h010);
      chk("aligned_seg_len", seg_len_log[0], 8);
      chk("aligned_pulses", hs_cnt, 8);
      got_q.delete();
      do_cmd(0, 'h010, 7, 0, 0, -1);
      wait_drain();
      chk_got("aligned_readback", 8'hA0, 8);

      // Write crossing a page boundary.
      for (int i = 0; i < 5; i++) wbuf.push_back(8'h11 + 8'(i));
      do_cmd(1, 'h006, 4, 0, 0, -1);
      chk("split_segments", seg_addr_log.size(), 2);
      if (seg_addr_log.size() == 2 && seg_len_log.size() == 2) begin
         chk("split_seg0_addr", seg_addr_log[0], 'h006);
         chk("split_seg0_len", seg_len_log[0], 2);
         chk("split_seg1_addr", seg_addr_log[1], 'h008);
         chk("split_seg1_len", seg_len_log[1], 3);
      end
      got_q.delete();
      do_cmd(0, 'h006, 4, 0, 0, -1);
      wait_drain();
      chk_got("split_readback", 8'h11, 5);

      // Top-of-memory single byte and wrapping two-byte write.
      wbuf.push_back(8'hC3);
      do_cmd(1, 'h7FF, 0, 0, 0, -1);
      chk("single_seg_len", seg_len_log[0], 1);
      wbuf.push_back(8'hD1); wbuf.push_back(8'hD2);
      do_cmd(1, 'h7FF, 1, 0, 0, -1);
      chk("wrap_segments", seg_addr_log.size(), 2);
      if (seg_addr_log.size() == 2) begin
         chk("wrap_seg0_addr", seg_addr_log[0], 'h7FF);
         chk("wrap_seg1_addr", seg_addr_log[1], 'h000);
      end
      got_q.delete();
      do_cmd(0, 'h7FF, 1, 0, 0, -1);
      wait_drain();
      chk_got("wrap_readback", 8'hD1, 2);

      // Full read with the consumer stalled; read space must gate the next read.
      rd_hold = 1; rd_release = 0;
      do_cmd(0, 'h000, 15, 0, 0, -1);
      chk("bp_buffered", rdata_valid, 1);
      cmd_wr = 1'b0; cmd_len = '0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("bp_cmd_ready_full", cmd_ready, 0);
      end
      rd_release = 1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk); #2;
         if (rd_release == 0) break;
      end
      @(negedge clk); #1;
      chk("bp_cmd_ready_after_pop", cmd_ready, 1);
      cmd_wr = 1'b1; rd_hold = 0;
      do_cmd(0, 'h010, 0, 0, 0, -1);
      wait_drain();

      // Slow write data, then bytes go out back-to-back.
      ctl_always = 1;
      do_cmd(1, 'h020, 3, 2, 1, -1);
      ctl_always = 0;

      // Reset while byte 3 of 8 is in flight, then a clean write/read.
      do_cmd(1, 'h030, 7, 0, 0, 2);
      wbuf.push_back(8'h5A);
      do_cmd(1, 'h100, 0, 0, 0, -1);
      got_q.delete();
      do_cmd(0, 'h100, 0, 0, 0, -1);
      wait_drain();
      chk_got("post_reset_readback", 8'h5A, 1);

      // Random commands.
      for (int n = 0; n < 40; n++)
         do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, MEM_SIZE - 1),
                $urandom_range(0, (1 << LEN_W) - 1), $urandom_range(0, 2), 0, -1);
      wait_drain();
      @(negedge clk); #1;
      chk("final_rdata_valid", rdata_valid, 0);
      chk("final_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
